// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR engine: step-mode encoding and
// maximal-length feedback masks for common widths.
package lfsr_pkg;

    typedef enum logic {
        LFSR_FIB = 1'b0,
        LFSR_GAL = 1'b1
    } lfsr_mode_e;

    // Bit i set means stage i+1 feeds back (x^16+x^14+x^13+x^11+1 -> 16'hB400).
    localparam logic [3:0]  LFSR_TAPS_W4  = 4'hC;
    localparam logic [7:0]  LFSR_TAPS_W8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_W16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_W32 = 32'h8020_0003;

endpackage

// File: rtl/lfsr_step.sv
// Pure next-state function of the LFSR: one Fibonacci or Galois shift of
// the current state under the given feedback mask.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] state,
    input  lfsr_mode_e       mode,
    input  logic [WIDTH-1:0] taps,
    output logic [WIDTH-1:0] next
);

    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        next = '0;
        if (mode == LFSR_GAL) begin
            next = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? taps : '0);
        end else begin
            next = {state[WIDTH-2:0], ^(state & taps)};
        end
    end

endmodule

// File: rtl/lfsr_engine.sv
// Configurable LFSR with load, all-zero lock-up recovery and measurement of
// the period between returns to the last loaded (origin) state.
module lfsr_engine
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_W16,
    parameter logic [WIDTH-1:0] SEED  = '1,
    parameter int               CNT_W = WIDTH + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] match_value,
    output logic [WIDTH-1:0] out,
    output logic             bit_out,
    output logic             match,
    output logic             lockup,
    output logic             wrap,
    output logic [CNT_W-1:0] period_len
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] origin;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic [WIDTH-1:0] step_next;

    lfsr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .state (out),
        .mode  (lfsr_mode_e'(mode)),
        .taps  (TAPS),
        .next  (step_next)
    );

    // Saturating increment; also used for period_len so it can never wrap to a short value.
    assign count_inc = (count == CNT_MAX) ? count : count + CNT_W'(1);

    assign bit_out = out[WIDTH-1];
    assign match   = (out == match_value);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out        <= SEED;
            origin     <= SEED;
            count      <= '0;
            period_len <= '0;
            lockup     <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values.
            lockup <= 1'b0;
            wrap   <= 1'b0;
            if (load) begin
                out        <= load_value;
                origin     <= load_value;
                count      <= '0;
                period_len <= '0;
            end else if (enable) begin
                if (out == '0) begin
                    out    <= SEED;
                    lockup <= 1'b1;
                    count  <= '0;
                end else begin
                    out <= step_next;
                    if (step_next == origin) begin
                        wrap       <= 1'b1;
                        period_len <= count_inc;
                        count      <= '0;
                    end else begin
                        count <= count_inc;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_engine.sv
// Scoreboard bench: two 4-bit engines (taps C and 3) driven in lockstep against
// an arithmetic reference model; a monitor pops and checks one entry per edge.
module tb_lfsr_engine;

    localparam int W  = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable, mode, load;
    logic [W-1:0]  load_value, match_value;
    logic [W-1:0]  out_a, out_b;
    logic          bit_a, bit_b, match_a, match_b, lock_a, lock_b, wrap_a, wrap_b;
    logic [CW-1:0] plen_a, plen_b;

    always #5 clk = ~clk;

    lfsr_engine #(.WIDTH(W), .TAPS(4'hC), .SEED(4'hF), .CNT_W(CW)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .load(load),
        .load_value(load_value), .match_value(match_value), .out(out_a),
        .bit_out(bit_a), .match(match_a), .lockup(lock_a), .wrap(wrap_a),
        .period_len(plen_a)
    );

    lfsr_engine #(.WIDTH(W), .TAPS(4'h3), .SEED(4'hF), .CNT_W(CW)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .load(load),
        .load_value(load_value), .match_value(match_value), .out(out_b),
        .bit_out(bit_b), .match(match_b), .lockup(lock_b), .wrap(wrap_b),
        .period_len(plen_b)
    );

    typedef struct {
        int out[2];
        int lock[2];
        int wrap[2];
        int plen[2];
        int match[2];
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: plain integers, one entry per engine.
    int m_out[2], m_org[2], m_cnt[2], m_plen[2], m_lock[2], m_wrap[2];
    int taps_of[2] = '{12, 3};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int model_step(int s, int taps, int gal);
        if (gal != 0) return ((s * 2) % 16) ^ ((s >= 8) ? taps : 0);
        return ((s * 2) % 16) + ($countones(s & taps) % 2);
    endfunction

    function automatic int sat_inc(int c);
        return (c >= 31) ? 31 : c + 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_out[k] = 15; m_org[k] = 15; m_cnt[k] = 0; m_plen[k] = 0;
            m_lock[k] = 0; m_wrap[k] = 0;
        end
    endtask

    task automatic model_cycle(input int ld, input int lv, input int en, input int md);
        for (int k = 0; k < 2; k++) begin
            m_lock[k] = 0;
            m_wrap[k] = 0;
            if (ld != 0) begin
                m_out[k] = lv; m_org[k] = lv; m_cnt[k] = 0; m_plen[k] = 0;
            end else if (en != 0) begin
                if (m_out[k] == 0) begin
                    m_out[k] = 15; m_lock[k] = 1; m_cnt[k] = 0;
                end else begin
                    int nx;
                    nx = model_step(m_out[k], taps_of[k], md);
                    if (nx == m_org[k]) begin
                        m_wrap[k] = 1; m_plen[k] = sat_inc(m_cnt[k]); m_cnt[k] = 0;
                    end else begin
                        m_cnt[k] = sat_inc(m_cnt[k]);
                    end
                    m_out[k] = nx;
                end
            end
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue what the next rising edge must show.
    task automatic drive(input int rst, input int ld, input int lv, input int en, input int md, input int mv);
        exp_t e;
        @(negedge clk);
        reset       = rst[0];
        load        = ld[0];
        load_value  = lv[W-1:0];
        enable      = en[0];
        mode        = md[0];
        match_value = mv[W-1:0];
        if (rst != 0) model_reset();
        else          model_cycle(ld, lv, en, md);
        for (int k = 0; k < 2; k++) begin
            e.out[k]   = m_out[k];
            e.lock[k]  = m_lock[k];
            e.wrap[k]  = m_wrap[k];
            e.plen[k]  = m_plen[k];
            e.match[k] = (m_out[k] == mv) ? 1 : 0;
        end
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("out_a",    32'(out_a),   32'(e.out[0]));
            check("out_b",    32'(out_b),   32'(e.out[1]));
            check("bit_a",    32'(bit_a),   32'(e.out[0] / 8));
            check("bit_b",    32'(bit_b),   32'(e.out[1] / 8));
            check("lockup_a", 32'(lock_a),  32'(e.lock[0]));
            check("lockup_b", 32'(lock_b),  32'(e.lock[1]));
            check("wrap_a",   32'(wrap_a),  32'(e.wrap[0]));
            check("wrap_b",   32'(wrap_b),  32'(e.wrap[1]));
            check("plen_a",   32'(plen_a),  32'(e.plen[0]));
            check("plen_b",   32'(plen_b),  32'(e.plen[1]));
            check("match_a",  32'(match_a), 32'(e.match[0]));
            check("match_b",  32'(match_b), 32'(e.match[1]));
        end
    end

    initial begin
        int md_r;
        reset = 1'b1; load = 1'b0; enable = 1'b0; mode = 1'b0;
        load_value = '0; match_value = '0;
        model_reset();
        #3;
        check("reset_out",    32'(out_a), 32'hF);
        check("reset_wrap",   32'(wrap_a | lock_a), 32'h0);
        check("reset_plen",   32'(plen_a), 32'h0);

        drive(1, 0, 0, 1, 0, 0);
        drive(1, 1, 5, 1, 0, 0);

        // Fibonacci, taps C: F,E,C,8,1,2,4,9,3,6,D,A,5,B,7,F repeated; match on D.
        for (int i = 0; i < 32; i++) drive(0, 0, 0, 1, 0, 13);
        @(posedge clk); #2;
        check("fib_period_a", 32'(plen_a), 32'd15);

        // Galois from 1: taps 3 gives 1,2,4,8,3,6,C,B,5,A,7,E,F,D,9,1.
        drive(0, 1, 1, 0, 1, 0);
        for (int i = 0; i < 30; i++) drive(0, 0, 0, 1, 1, 13);
        @(posedge clk); #2;
        check("gal_period_b", 32'(plen_b), 32'd15);

        // Loaded zero holds while idle, then recovers to SEED with a one-cycle lockup pulse.
        drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 15);

        // Load and enable together: load wins, no step.
        drive(0, 1, 6, 1, 0, 6);
        @(posedge clk); #2;
        check("load_prio_out", 32'(out_a), 32'h6);
        check("load_prio_plen", 32'(plen_a), 32'h0);

        // Randomized traffic with occasional loads (often of zero) and mode flips.
        md_r = 0;
        for (int i = 0; i < 400; i++) begin
            int ld, lv, en, mv;
            ld = ($urandom_range(0, 15) == 0) ? 1 : 0;
            lv = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
            en = ($urandom_range(0, 3) != 0) ? 1 : 0;
            if ($urandom_range(0, 19) == 0) md_r = 1 - md_r;
            mv = ($urandom_range(0, 1) == 0) ? m_out[0] : $urandom_range(0, 15);
            drive(0, ld, lv, en, md_r, mv);
        end

        // Asynchronous reset between edges, then restart F,E,C.
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0, 0);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("async_out_a",  32'(out_a), 32'hF);
        check("async_out_b",  32'(out_b), 32'hF);
        check("async_flags",  32'({wrap_a, lock_a, wrap_b, lock_b}), 32'h0);
        check("async_plen",   32'(plen_a), 32'h0);
        model_reset();
        drive(1, 1, 3, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 12);

        begin
            int budget;
            budget = 0;
            while (sb.size() > 0 && budget < 10) begin
                @(posedge clk);
                budget++;
            end
            #2;
            check("scoreboard_drained", 32'(sb.size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lfsr_engine.md
LFSR_ENGINE -- requirements
Module: lfsr_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 16, register width (legal range 3..64).
REQ-002 SHALL have parameter TAPS, default 16'hB400, WIDTH-bit feedback mask.
REQ-003 SHALL have parameter SEED, default all ones, WIDTH-bit reset and lock-up recovery value.
REQ-004 SHALL have parameter CNT_W, default WIDTH+1, width of the period counter.
REQ-005 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port enable, input, 1: advance one step this cycle.
REQ-008 SHALL have port mode, input, 1: 0 = Fibonacci, 1 = Galois.
REQ-009 SHALL have port load, input, 1: load load_value this cycle.
REQ-010 SHALL have port load_value, input, WIDTH: state to load.
REQ-011 SHALL have port match_value, input, WIDTH: compare pattern.
REQ-012 SHALL have port out, output, WIDTH: current LFSR state.
REQ-013 SHALL have port bit_out, output, 1: equal to out[WIDTH-1].
REQ-014 SHALL have port match, output, 1: combinational (out == match_value).
REQ-015 SHALL have port lockup, output, 1: registered one-cycle pulse on all-zero recovery.
REQ-016 SHALL have port wrap, output, 1: registered one-cycle pulse on return to origin.
REQ-017 SHALL have port period_len, output, CNT_W: step count of the last completed period.

Function
REQ-018 Fibonacci step SHALL be next = {out[WIDTH-2:0], XOR-reduce(out & TAPS)}.
REQ-019 Galois step SHALL be next = {out[WIDTH-2:0],1'b0} XOR (out[WIDTH-1] ? TAPS : 0).
REQ-020 Priority SHALL be load > enable > hold; a load takes effect on the next edge regardless of enable.
REQ-021 A load SHALL also set the origin register to load_value, clear the step counter and clear period_len to 0.
REQ-022 When enable=1, load=0 and out==0, the next state SHALL be SEED, lockup SHALL pulse for one cycle, and the step counter SHALL clear.
REQ-023 When load_value==0, the engine SHALL load zero; lock-up recovery SHALL occur on the first enabled step after the load.
REQ-024 Each enabled, non-lock-up step SHALL increment the step counter; the counter SHALL saturate at all ones.
REQ-025 When a step produces next == origin, wrap SHALL pulse in the following cycle, period_len SHALL take counter+1, and the counter SHALL clear.
REQ-026 Changing mode mid-sequence SHALL apply the new step rule on the next enabled step with no other side effects.
REQ-027 lockup and wrap SHALL deassert on any cycle without a qualifying step.

Reset
REQ-028 Reset SHALL set out=SEED, origin=SEED, counter=0, period_len=0, lockup=0 and wrap=0.
REQ-029 Reset asserted mid-operation SHALL override load and enable immediately; the first step after release SHALL start from SEED.

Structure
REQ-030 Package lfsr_pkg SHALL hold the mode encoding constants (LFSR_FIB=0, LFSR_GAL=1) and default maximal-length tap masks for widths 4, 8, 16 and 32.
REQ-031 Next-state logic SHALL be a combinational sub-module lfsr_step (inputs: state, mode, TAPS; output: next).
REQ-032 All registers SHALL reside in lfsr_engine.

Verification
REQ-033 Test: WIDTH=4, TAPS=4'b1100, SEED=4'hF, mode=0, enable=1 -> out sequence F,E,C,8,1,2,4,9,3,6,D,A,5,B,7,F; wrap pulses once per cycle; period_len=15.
REQ-034 Test: WIDTH=4, TAPS=4'b0011, load 4'h1, mode=1 -> 1,2,4,8,3,6,C,B,5,A,7,E,F,D,9,1; period_len=15.
REQ-035 Test: load 4'h0, then enable -> out=0 holds while enable=0; first enabled step gives out=SEED and lockup=1 for exactly one cycle.
REQ-036 Test: load=1 and enable=1 in the same cycle with load_value=4'h6 -> out=6 next cycle, no step taken, period_len=0.
REQ-037 Test: reset asserted asynchronously mid-sequence -> out=F immediately with no clock edge, wrap=0, lockup=0; the sequence restarts F,E,C.
REQ-038 Test: match_value=4'hD during REQ-033 -> match high only in the cycle where out=D.
